// File: rtl/watchdog.sv
// Watchdog timer: arm with a period, service with kick, warn after one silent period, bite after a second.
// Optional window mode (early kicks bite) is compiled in when WATCHDOG_WINDOW_EN is defined.
module watchdog #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] value,
  input  logic         start,
  input  logic         kick,
  input  logic         stop,
  output logic         active,
  output logic         warn,
  output logic         bite,
  output logic [W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WARN  = 2'd2,
    BITE  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] period_q, period_d;
  logic         last_tick;

  // State, countdown and period registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
    end
  end

  // Next-state logic; priority is stop > kick > expiry
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    last_tick = (count_q <= W'(1));
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (start && (value != '0)) begin
          period_d = value;
          count_d  = value;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (kick) begin
`ifdef WATCHDOG_WINDOW_EN
          if (count_q > (period_q >> 1)) begin
            state_d = BITE;
            count_d = '0;
          end else begin
            count_d = period_q;
          end
`else
          count_d = period_q;
`endif
        end else if (last_tick) begin
          state_d = WARN;
          count_d = period_q;
        end else begin
          count_d = count_q - W'(1);
        end
      end
      WARN: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (kick) begin
          state_d = ARMED;
          count_d = period_q;
        end else if (last_tick) begin
          state_d = BITE;
          count_d = '0;
        end else begin
          count_d = count_q - W'(1);
        end
      end
      BITE: begin
        count_d = '0;
        if (stop) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Outputs decoded from registered state only
  assign active = (state_q != IDLE);
  assign warn   = (state_q == WARN);
  assign bite   = (state_q == BITE);
  assign count  = count_q;

endmodule

// File: tb/tb_watchdog.sv
// Directed, table-driven bench for watchdog, plus hand-written reset and window sequences.
module tb_watchdog;

  logic       clock;
  logic       reset;
  logic [7:0] value;
  logic       start, kick, stop;
  logic       active, warn, bite;
  logic [7:0] count;

  int compared = 0;
  int mism     = 0;

  watchdog #(.W(8)) dut (
    .clock (clock),
    .reset (reset),
    .value (value),
    .start (start),
    .kick  (kick),
    .stop  (stop),
    .active(active),
    .warn  (warn),
    .bite  (bite),
    .count (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic       kk;
    logic       sp;
    logic [7:0] val;
    logic       ea;
    logic       ew;
    logic       eb;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic kk, logic sp, logic [7:0] val,
                              logic ea, logic ew, logic eb, logic [7:0] ec);
    vec_t v;
    v.st = st; v.kk = kk; v.sp = sp; v.val = val;
    v.ea = ea; v.ew = ew; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ea, input logic ew,
                         input logic eb, input logic [7:0] ec);
    chk({tag, "_active"}, 32'(active), 32'(ea));
    chk({tag, "_warn"},   32'(warn),   32'(ew));
    chk({tag, "_bite"},   32'(bite),   32'(eb));
    chk({tag, "_count"},  32'(count),  32'(ec));
  endtask

  task automatic drive(input logic st, input logic kk, input logic sp, input logic [7:0] val);
    start = st; kick = kk; stop = sp; value = val;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input string tag, input logic st, input logic kk, input logic sp,
                     input logic [7:0] val, input logic ea, input logic ew,
                     input logic eb, input logic [7:0] ec);
    drive(st, kk, sp, val);
    step();
    chk_out(tag, ea, ew, eb, ec);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 8'd0);
    #2 reset = 1'b0;
    #1 chk_out("reset_async", 0, 0, 0, 8'd0);
    step();
    step();
    chk_out("reset_held", 0, 0, 0, 8'd0);
    reset = 1'b1;

    //           st kk sp val     a  w  b  cnt
    // Unserviced countdown: 5 ARMED, 5 WARN, then BITE held
    tbl.push_back(mk(1, 0, 0, 8'd5,   1, 0, 0, 8'd5));
    tbl.push_back(mk(0, 0, 0, 8'd5,   1, 0, 0, 8'd4));
    tbl.push_back(mk(0, 0, 0, 8'd5,   1, 0, 0, 8'd3));
    tbl.push_back(mk(0, 0, 0, 8'd5,   1, 0, 0, 8'd2));
    tbl.push_back(mk(0, 0, 0, 8'd5,   1, 0, 0, 8'd1));
    tbl.push_back(mk(0, 0, 0, 8'd5,   1, 1, 0, 8'd5));
    tbl.push_back(mk(0, 0, 0, 8'd5,   1, 1, 0, 8'd4));
    tbl.push_back(mk(0, 0, 0, 8'd5,   1, 1, 0, 8'd3));
    tbl.push_back(mk(0, 0, 0, 8'd5,   1, 1, 0, 8'd2));
    tbl.push_back(mk(0, 0, 0, 8'd5,   1, 1, 0, 8'd1));
    tbl.push_back(mk(0, 0, 0, 8'd5,   1, 0, 1, 8'd0));
    tbl.push_back(mk(0, 1, 0, 8'd5,   1, 0, 1, 8'd0));
    tbl.push_back(mk(1, 0, 0, 8'd3,   1, 0, 1, 8'd0));
    tbl.push_back(mk(0, 0, 1, 8'd3,   0, 0, 0, 8'd0));
    // Kicks every 3rd cycle keep warn low
    tbl.push_back(mk(1, 0, 0, 8'd4,   1, 0, 0, 8'd4));
    tbl.push_back(mk(0, 0, 0, 8'd4,   1, 0, 0, 8'd3));
    tbl.push_back(mk(0, 0, 0, 8'd4,   1, 0, 0, 8'd2));
    tbl.push_back(mk(0, 1, 0, 8'd4,   1, 0, 0, 8'd4));
    tbl.push_back(mk(0, 0, 0, 8'd4,   1, 0, 0, 8'd3));
    tbl.push_back(mk(0, 0, 0, 8'd4,   1, 0, 0, 8'd2));
    tbl.push_back(mk(0, 1, 0, 8'd4,   1, 0, 0, 8'd4));
    tbl.push_back(mk(0, 0, 0, 8'd4,   1, 0, 0, 8'd3));
    tbl.push_back(mk(0, 0, 0, 8'd4,   1, 0, 0, 8'd2));
    tbl.push_back(mk(0, 1, 0, 8'd4,   1, 0, 0, 8'd4));
    tbl.push_back(mk(0, 0, 1, 8'd4,   0, 0, 0, 8'd0));
    // Kick during WARN returns to ARMED with a full reload
    tbl.push_back(mk(1, 0, 0, 8'd3,   1, 0, 0, 8'd3));
    tbl.push_back(mk(0, 0, 0, 8'd3,   1, 0, 0, 8'd2));
    tbl.push_back(mk(0, 0, 0, 8'd3,   1, 0, 0, 8'd1));
    tbl.push_back(mk(0, 0, 0, 8'd3,   1, 1, 0, 8'd3));
    tbl.push_back(mk(0, 1, 0, 8'd3,   1, 0, 0, 8'd3));
    tbl.push_back(mk(0, 0, 0, 8'd3,   1, 0, 0, 8'd2));
    tbl.push_back(mk(0, 1, 1, 8'd3,   0, 0, 0, 8'd0));
    // Zero start ignored; kick/stop ignored in IDLE
    tbl.push_back(mk(1, 0, 0, 8'd0,   0, 0, 0, 8'd0));
    tbl.push_back(mk(0, 1, 0, 8'd7,   0, 0, 0, 8'd0));
    tbl.push_back(mk(0, 0, 1, 8'd7,   0, 0, 0, 8'd0));
    // value changes mid-count do not affect the latched period
    tbl.push_back(mk(1, 0, 0, 8'd6,   1, 0, 0, 8'd6));
    tbl.push_back(mk(0, 0, 0, 8'd9,   1, 0, 0, 8'd5));
    tbl.push_back(mk(1, 0, 0, 8'd9,   1, 0, 0, 8'd4));
    tbl.push_back(mk(0, 0, 0, 8'd9,   1, 0, 0, 8'd3));
    tbl.push_back(mk(0, 1, 0, 8'd2,   1, 0, 0, 8'd6));
    tbl.push_back(mk(0, 0, 0, 8'd0,   1, 0, 0, 8'd5));
    tbl.push_back(mk(0, 0, 1, 8'd0,   0, 0, 0, 8'd0));
    // Period of 1 and maximum period
    tbl.push_back(mk(1, 0, 0, 8'd1,   1, 0, 0, 8'd1));
    tbl.push_back(mk(0, 0, 0, 8'd1,   1, 1, 0, 8'd1));
    tbl.push_back(mk(0, 0, 0, 8'd1,   1, 0, 1, 8'd0));
    tbl.push_back(mk(0, 0, 1, 8'd1,   0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 0, 0, 8'd255, 1, 0, 0, 8'd255));
    tbl.push_back(mk(0, 0, 0, 8'd255, 1, 0, 0, 8'd254));
    tbl.push_back(mk(0, 0, 1, 8'd255, 0, 0, 0, 8'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      run($sformatf("vec%0d", i), tbl[i].st, tbl[i].kk, tbl[i].sp, tbl[i].val,
          tbl[i].ea, tbl[i].ew, tbl[i].eb, tbl[i].ec);
    end

    // Asynchronous reset in the middle of WARN, then kick must not re-arm
    run("ar_start", 1, 0, 0, 8'd2, 1, 0, 0, 8'd2);
    run("ar_arm",   0, 0, 0, 8'd2, 1, 0, 0, 8'd1);
    run("ar_warn",  0, 0, 0, 8'd2, 1, 1, 0, 8'd2);
    #2 reset = 1'b0;
    #1 chk_out("ar_async", 0, 0, 0, 8'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run($sformatf("ar_kick%0d", i), 0, 1, 0, 8'd2, 0, 0, 0, 8'd0);
    end
    run("ar_restart", 1, 0, 0, 8'd2, 1, 0, 0, 8'd2);
    run("ar_stop",    0, 0, 1, 8'd2, 0, 0, 0, 8'd0);

    // Kick timing against the half-period window, value = 8
    run("win_a_start", 1, 0, 0, 8'd8, 1, 0, 0, 8'd8);
    run("win_a_c7",    0, 0, 0, 8'd8, 1, 0, 0, 8'd7);
    run("win_a_c6",    0, 0, 0, 8'd8, 1, 0, 0, 8'd6);
`ifdef WATCHDOG_WINDOW_EN
    run("win_a_early", 0, 1, 0, 8'd8, 1, 0, 1, 8'd0);
    run("win_a_hold",  0, 0, 0, 8'd8, 1, 0, 1, 8'd0);
`else
    run("win_a_kick",  0, 1, 0, 8'd8, 1, 0, 0, 8'd8);
    run("win_a_next",  0, 0, 0, 8'd8, 1, 0, 0, 8'd7);
`endif
    run("win_a_stop",  0, 0, 1, 8'd8, 0, 0, 0, 8'd0);
    run("win_b_start", 1, 0, 0, 8'd8, 1, 0, 0, 8'd8);
    for (int c = 7; c >= 4; c--) begin
      run($sformatf("win_b_c%0d", c), 0, 0, 0, 8'd8, 1, 0, 0, 8'(c));
    end
    run("win_b_kick",  0, 1, 0, 8'd8, 1, 0, 0, 8'd8);
    run("win_b_next",  0, 0, 0, 8'd8, 1, 0, 0, 8'd7);
    run("win_b_stop",  0, 0, 1, 8'd8, 0, 0, 0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
